// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the default Tnew width and
// the saturating Tnew decrement that the hazard unit also uses.
package pipe_pkg;

  localparam int PC_W           = 32;
  localparam int REG_A_W        = 5;
  localparam int TNEW_W_DEFAULT = 4;

  // Saturating decrement: a result that is already available stays at zero
  // instead of wrapping round to the maximum count.
  function automatic logic [TNEW_W_DEFAULT-1:0] tnew_dec(input logic [TNEW_W_DEFAULT-1:0] tnew);
    logic [TNEW_W_DEFAULT-1:0] res;
    if (tnew == {TNEW_W_DEFAULT{1'b0}}) begin
      res = {TNEW_W_DEFAULT{1'b0}};
    end else begin
      res = tnew - {{(TNEW_W_DEFAULT-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle: upstream slot fields and stall/flush controls in,
// registered slot fields and the forward-ready flag out.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int TNEW_W    = TNEW_W_DEFAULT
);

  logic                 en;
  logic                 clear;
  logic                 in_valid;
  logic [PC_W-1:0]      in_pc;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [REG_A_W-1:0]   in_a3;
  logic                 in_reg_write;
  logic [TNEW_W-1:0]    in_tnew;

  logic                 out_valid;
  logic [PC_W-1:0]      out_pc;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [REG_A_W-1:0]   out_a3;
  logic                 out_reg_write;
  logic [TNEW_W-1:0]    out_tnew;
  logic                 out_fwd_ready;

  // Upstream stage / hazard unit side.
  modport master (
    output en, clear, in_valid, in_pc, in_payload, in_a3, in_reg_write, in_tnew,
    input  out_valid, out_pc, out_payload, out_a3, out_reg_write, out_tnew, out_fwd_ready
  );

  // Pipeline register side.
  modport slave (
    input  en, clear, in_valid, in_pc, in_payload, in_a3, in_reg_write, in_tnew,
    output out_valid, out_pc, out_payload, out_a3, out_reg_write, out_tnew, out_fwd_ready
  );

endinterface

// File: rtl/pipe_tnew_ctr.sv
// Tnew countdown register: decrements (saturating) on advance, holds on
// stall, zeroes on flush or reset. Exposes its next value so forward-ready
// can be registered in step with the count.
module pipe_tnew_ctr
  import pipe_pkg::*;
#(
  parameter int TNEW_W = TNEW_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic [TNEW_W-1:0] tnew_next,
  output logic [TNEW_W-1:0] tnew
);

  logic [TNEW_W-1:0] dec_s;
  logic [TNEW_W-1:0] tnew_r;

  generate
    if (TNEW_W == TNEW_W_DEFAULT) begin : g_pkg_dec
      // Shared decrement when the width matches the package default.
      always_comb begin
        dec_s = tnew_dec(in_tnew);
      end
    end else begin : g_local_dec
      // Same saturating decrement for a non-default counter width.
      always_comb begin
        if (in_tnew == {TNEW_W{1'b0}}) begin
          dec_s = {TNEW_W{1'b0}};
        end else begin
          dec_s = in_tnew - {{(TNEW_W-1){1'b0}}, 1'b1};
        end
      end
    end
  endgenerate

  // Next count: flush beats advance, stall holds without decrementing.
  always_comb begin
    tnew_next = tnew_r;
    if (clear) begin
      tnew_next = {TNEW_W{1'b0}};
    end else if (en) begin
      tnew_next = dec_s;
    end else begin
      tnew_next = tnew_r;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tnew_r <= {TNEW_W{1'b0}};
    end else begin
      tnew_r <= tnew_next;
    end
  end

  assign tnew = tnew_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Uniform inter-stage pipeline register (D/E, E/M, M/W) with stall, flush
// and a registered forward-ready flag.
// Optional feature macro: PIPE_BUBBLE_KEEP_PC_EN -- when defined, a flush
// bubble keeps the PC of the slot it replaces instead of loading PC_RESET.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              PAYLOAD_W = 64,
  parameter int              TNEW_W    = TNEW_W_DEFAULT,
  parameter logic [PC_W-1:0] PC_RESET  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);

  logic                 valid_r;
  logic [PC_W-1:0]      pc_r;
  logic [PAYLOAD_W-1:0] payload_r;
  logic [REG_A_W-1:0]   a3_r;
  logic                 reg_write_r;
  logic                 fwd_ready_r;
  logic [TNEW_W-1:0]    tnew_r;

  logic                 rw_gated_s;
  logic                 valid_next_s;
  logic [PC_W-1:0]      pc_next_s;
  logic [PAYLOAD_W-1:0] payload_next_s;
  logic [REG_A_W-1:0]   a3_next_s;
  logic                 reg_write_next_s;
  logic                 fwd_ready_next_s;
  logic [TNEW_W-1:0]    tnew_next_s;
  logic [PC_W-1:0]      bubble_pc_s;

  pipe_tnew_ctr #(
    .TNEW_W (TNEW_W)
  ) u_tnew_ctr (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .clear     (bus.clear),
    .in_tnew   (bus.in_tnew),
    .tnew_next (tnew_next_s),
    .tnew      (tnew_r)
  );

`ifdef PIPE_BUBBLE_KEEP_PC_EN
  assign bubble_pc_s = bus.in_pc;
`else
  assign bubble_pc_s = PC_RESET;
`endif

  // Writes to $0 or from empty slots are dropped so hazard compares stay quiet.
  assign rw_gated_s = bus.in_reg_write & bus.in_valid & (bus.in_a3 != {REG_A_W{1'b0}});

  // Next-state selection: flush bubble, advance capture, or stall hold.
  always_comb begin
    valid_next_s     = valid_r;
    pc_next_s        = pc_r;
    payload_next_s   = payload_r;
    a3_next_s        = a3_r;
    reg_write_next_s = reg_write_r;
    if (bus.clear) begin
      valid_next_s     = 1'b0;
      pc_next_s        = bubble_pc_s;
      payload_next_s   = {PAYLOAD_W{1'b0}};
      a3_next_s        = {REG_A_W{1'b0}};
      reg_write_next_s = 1'b0;
    end else if (bus.en) begin
      valid_next_s     = bus.in_valid;
      pc_next_s        = bus.in_pc;
      payload_next_s   = bus.in_payload;
      a3_next_s        = rw_gated_s ? bus.in_a3 : {REG_A_W{1'b0}};
      reg_write_next_s = rw_gated_s;
    end else begin
      valid_next_s     = valid_r;
      pc_next_s        = pc_r;
      payload_next_s   = payload_r;
      a3_next_s        = a3_r;
      reg_write_next_s = reg_write_r;
    end
  end

  // Forward-ready derived from next-state so it lines up with the slot fields.
  always_comb begin
    fwd_ready_next_s = valid_next_s & reg_write_next_s
                     & (a3_next_s != {REG_A_W{1'b0}})
                     & (tnew_next_s == {TNEW_W{1'b0}});
  end

  // Slot field registers; reset has top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r     <= 1'b0;
      pc_r        <= PC_RESET;
      payload_r   <= {PAYLOAD_W{1'b0}};
      a3_r        <= {REG_A_W{1'b0}};
      reg_write_r <= 1'b0;
      fwd_ready_r <= 1'b0;
    end else begin
      valid_r     <= valid_next_s;
      pc_r        <= pc_next_s;
      payload_r   <= payload_next_s;
      a3_r        <= a3_next_s;
      reg_write_r <= reg_write_next_s;
      fwd_ready_r <= fwd_ready_next_s;
    end
  end

  assign bus.out_valid     = valid_r;
  assign bus.out_pc        = pc_r;
  assign bus.out_payload   = payload_r;
  assign bus.out_a3        = a3_r;
  assign bus.out_reg_write = reg_write_r;
  assign bus.out_tnew      = tnew_r;
  assign bus.out_fwd_ready = fwd_ready_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, Tnew countdown, $0/invalid
// gating, stall hold, flush bubble (both PC configurations) and reset priority.
module tb_pipe_stage_reg;

  localparam logic [31:0] PC_RST = 32'hBFC0_0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  logic [31:0] exp_bubble_pc;

  pipe_stage_reg_if #(.PAYLOAD_W(64), .TNEW_W(4)) bus ();

  pipe_stage_reg #(
    .PAYLOAD_W (64),
    .TNEW_W    (4),
    .PC_RESET  (PC_RST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic clear, input logic valid,
                       input logic [31:0] pc, input logic [63:0] payload,
                       input logic [4:0] a3, input logic rw, input logic [3:0] tnew);
    bus.en           = en;
    bus.clear        = clear;
    bus.in_valid     = valid;
    bus.in_pc        = pc;
    bus.in_payload   = payload;
    bus.in_a3        = a3;
    bus.in_reg_write = rw;
    bus.in_tnew      = tnew;
  endtask

  task automatic chk_bubble(input string tag, input logic [31:0] pc_exp);
    chk({tag, "_valid"},   64'(bus.out_valid),     64'd0);
    chk({tag, "_pc"},      64'(bus.out_pc),        64'(pc_exp));
    chk({tag, "_payload"}, bus.out_payload,        64'd0);
    chk({tag, "_a3"},      64'(bus.out_a3),        64'd0);
    chk({tag, "_rw"},      64'(bus.out_reg_write), 64'd0);
    chk({tag, "_tnew"},    64'(bus.out_tnew),      64'd0);
    chk({tag, "_fwd"},     64'(bus.out_fwd_ready), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
`ifdef PIPE_BUBBLE_KEEP_PC_EN
    exp_bubble_pc = 32'h0000_3008;
`else
    exp_bubble_pc = PC_RST;
`endif

    // Reset for two cycles with random inputs.
    reset = 1'b1;
    drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, {$urandom, $urandom},
          5'($urandom), 1'($urandom), 4'($urandom));
    step();
    drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, {$urandom, $urandom},
          5'($urandom), 1'($urandom), 4'($urandom));
    step();
    chk_bubble("reset", PC_RST);
    reset = 1'b0;

    // Advance with Tnew countdown.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3000, 64'h0000_0000_0000_0011, 5'd5, 1'b1, 4'd2);
    step();
    chk("adv1_valid",   64'(bus.out_valid),     64'd1);
    chk("adv1_pc",      64'(bus.out_pc),        64'h3000);
    chk("adv1_payload", bus.out_payload,        64'h11);
    chk("adv1_a3",      64'(bus.out_a3),        64'd5);
    chk("adv1_rw",      64'(bus.out_reg_write), 64'd1);
    chk("adv1_tnew",    64'(bus.out_tnew),      64'd1);
    chk("adv1_fwd",     64'(bus.out_fwd_ready), 64'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3004, 64'h22, 5'd5, 1'b1, 4'd1);
    step();
    chk("adv2_tnew", 64'(bus.out_tnew),      64'd0);
    chk("adv2_fwd",  64'(bus.out_fwd_ready), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3008, 64'h33, 5'd5, 1'b1, 4'd0);
    step();
    chk("adv3_tnew", 64'(bus.out_tnew),      64'd0);
    chk("adv3_fwd",  64'(bus.out_fwd_ready), 64'd1);
    chk("adv3_pc",   64'(bus.out_pc),        64'h3008);

    // Maximum Tnew stays within width.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_300C, 64'h44, 5'd6, 1'b1, 4'd15);
    step();
    chk("max_tnew", 64'(bus.out_tnew),      64'd14);
    chk("max_fwd",  64'(bus.out_fwd_ready), 64'd0);

    // $0 destination is dropped.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3010, 64'h55, 5'd0, 1'b1, 4'd0);
    step();
    chk("zero_rw",    64'(bus.out_reg_write), 64'd0);
    chk("zero_a3",    64'(bus.out_a3),        64'd0);
    chk("zero_valid", 64'(bus.out_valid),     64'd1);
    chk("zero_fwd",   64'(bus.out_fwd_ready), 64'd0);

    // Invalid slot is dropped.
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3014, 64'h66, 5'd7, 1'b1, 4'd0);
    step();
    chk("inv_rw",    64'(bus.out_reg_write), 64'd0);
    chk("inv_a3",    64'(bus.out_a3),        64'd0);
    chk("inv_valid", 64'(bus.out_valid),     64'd0);
    chk("inv_fwd",   64'(bus.out_fwd_ready), 64'd0);

    // Capture then stall three cycles with changing inputs.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3018, 64'hDEAD_BEEF_0000_0001, 5'd9, 1'b1, 4'd3);
    step();
    chk("cap_tnew", 64'(bus.out_tnew), 64'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0000_4000 + 32'(i), 64'h1234_0000 + 64'(i), 5'(i + 1), 1'b1, 4'd0);
      step();
      chk("stall_payload", bus.out_payload,        64'hDEAD_BEEF_0000_0001);
      chk("stall_tnew",    64'(bus.out_tnew),      64'd2);
      chk("stall_a3",      64'(bus.out_a3),        64'd9);
      chk("stall_pc",      64'(bus.out_pc),        64'h3018);
      chk("stall_fwd",     64'(bus.out_fwd_ready), 64'd0);
    end

    // Flush while stalled produces a bubble.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_3008, 64'h77, 5'd3, 1'b1, 4'd0);
    step();
    chk_bubble("flush", exp_bubble_pc);

    // Load a live slot, then reset, clear and en together.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_5000, 64'h88, 5'd4, 1'b1, 4'd5);
    step();
    chk("pre_rst_tnew", 64'(bus.out_tnew), 64'd4);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_6000, 64'h99, 5'd8, 1'b1, 4'd1);
    step();
    chk_bubble("rst_win", PC_RST);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the hand-written per-stage latches (D/E, E/M, M/W) with one block. It carries PC, a packed control/data payload, the destination register and its Tnew countdown. Stall (hold), flush (bubble insert) and a registered forward-ready flag are built in, so the hazard unit sees one uniform interface at every stage boundary.

## Interface
- PAYLOAD_W, 64, width of the opaque packed payload (RD1/RD2/ALU result/control bits, packed by the instantiating stage)
- TNEW_W, 4, width of the Tnew counter
- PC_RESET, 32'h0000_0000, value loaded into out_pc on reset
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; highest priority
- en  in  1  advance enable; 0 = stall (hold all outputs)
- clear  in  1  flush: load a bubble on the next edge
- in_valid  in  1  upstream slot holds a real instruction
- in_pc  in  32  instruction PC
- in_payload  in  PAYLOAD_W  packed stage data
- in_a3  in  5  destination register number
- in_reg_write  in  1  instruction writes GRF
- in_tnew  in  TNEW_W  cycles until result is produced, measured at the upstream stage
- out_valid, out_pc, out_payload, out_a3, out_reg_write, out_tnew  out  (matching widths)  registered copies
- out_fwd_ready  out  1  registered: out_valid & out_reg_write & (out_a3 != 0) & (out_tnew == 0)

## Operation
- Priority per edge: reset > clear > en > hold.
- reset: out_valid=0, out_pc=PC_RESET, out_payload=0, out_a3=0, out_reg_write=0, out_tnew=0, out_fwd_ready=0.
- clear (regardless of en): same values as reset, except out_pc (see Configuration).
- en=1, clear=0 (advance): capture in_* fields. The following rules apply on capture:
  - out_tnew = (in_tnew == 0) ? 0 : in_tnew − 1. This is a saturating decrement with no wrap.
  - out_reg_write = in_reg_write & in_valid & (in_a3 != 0). Writes to $0 and writes from invalid slots are dropped at capture.
  - out_a3 = in_a3 when the gated reg_write is 1, otherwise 0. This keeps the hazard comparators quiet.
  - out_payload and out_pc are captured unconditionally.
- en=0, clear=0 (stall): every output holds, including out_tnew. Tnew is not decremented while stalled.
- out_fwd_ready is computed from the next-state values, so it is aligned with the other outputs. It is never combinational from the inputs.

## Timing
- Latency: exactly 1 cycle from in_* to out_* when en=1.
- clear and en sampled on the same edge as data. A flush asserted with en=0 still produces a bubble.
- No combinational path from any input to any output.
- Reset mid-stall or mid-flush: reset wins and outputs take reset values on that edge.
- in_tnew = 2^TNEW_W − 1 yields out_tnew = 2^TNEW_W − 2. The arithmetic stays within TNEW_W bits.

## Configuration
- PIPE_BUBBLE_KEEP_PC_EN defined: on clear, out_pc loads in_pc instead of PC_RESET. The bubble then carries the PC of the slot it replaces, which is used for EPC and for debugging inserted stalls.
- Not defined: clear loads PC_RESET into out_pc, the same as reset.
- Neither setting changes the behaviour of any other field.

## Structure
- Shared package pipe_pkg holds:
  - constants PC_W=32, REG_A_W=5, and the default TNEW_W
  - the function tnew_dec(tnew), which performs the saturating decrement and is reused by the hazard unit
- One sub-module, pipe_tnew_ctr. It owns the out_tnew register and the decrement/hold/clear logic. It is instantiated once.
- All remaining fields are plain registers in the top module.

## Test plan
- Reset: hold reset=1 for 2 cycles with random inputs, then release. Required: all outputs 0, out_pc=PC_RESET, out_fwd_ready=0.
- Advance with Tnew decrement: in_tnew=2, in_a3=5, in_reg_write=1, in_valid=1, en=1. Required: next cycle out_tnew=1 and out_fwd_ready=0. Then feed in_tnew=1. Required: out_tnew=0 and out_fwd_ready=1. Then feed in_tnew=0. Required: out_tnew=0, with no wrap.
- $0 and invalid gating: in_a3=0 with reg_write=1 gives out_reg_write=0 and out_a3=0. Next, in_valid=0 with in_a3=7 gives the same result.
- Stall: capture payload=64'hDEAD_BEEF_0000_0001 with tnew=3, then hold en=0 for 3 cycles while the inputs change. Required: out_payload unchanged and out_tnew stays 2.
- Flush versus stall: en=0, clear=1, in_pc=32'h0000_3008. Required: out_valid=0 and out_reg_write=0. out_pc=32'h0000_3008 with PIPE_BUBBLE_KEEP_PC_EN defined, PC_RESET without it.
- Reset wins: reset=1, clear=1, en=1 on the same edge. Required: reset values, including out_pc=PC_RESET under both configurations.
